// File: rtl/cpu_pkg.sv
// Shared condition-code types for the condition/commit unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Combinational condition evaluation of an instruction cond field against NZCV.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  // NOTE: the default assignment ahead of the case keeps this block latch-free.
  always_comb begin
    o_cond_ex = 1'b1;
    case (cond_e'(i_cond))
      EQ:      o_cond_ex = w_z;
      NE:      o_cond_ex = !w_z;
      CS:      o_cond_ex = w_c;
      CC:      o_cond_ex = !w_c;
      MI:      o_cond_ex = w_n;
      PL:      o_cond_ex = !w_n;
      VS:      o_cond_ex = w_v;
      VC:      o_cond_ex = !w_v;
      HI:      o_cond_ex = w_c && !w_z;
      LS:      o_cond_ex = !w_c || w_z;
      GE:      o_cond_ex = (w_n == w_v);
      LT:      o_cond_ex = (w_n != w_v);
      GT:      o_cond_ex = !w_z && (w_n == w_v);
      LE:      o_cond_ex = w_z || (w_n != w_v);
      default: o_cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Resolves decoder write requests into committed enables; holds NZCV flags,
// a one-deep shadow copy for interrupt save/restore, and a saturating squash counter.
module cond_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             flag_save,
  input  logic             flag_rest,
  input  logic             cnt_clr,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  flags_t           r_flags;
  flags_t           r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cond_ex;
  logic             w_commit;

  cond_check u_cond_check (
    .i_cond    (cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_commit   = en && w_cond_ex;
  assign cond_ex    = w_cond_ex;
  assign pc_src     = w_commit && pcs;
  assign reg_write  = w_commit && reg_w;
  assign mem_write  = w_commit && mem_w;
  assign flags_q    = r_flags;
  assign squash_cnt = r_cnt;

  // Restore takes precedence over any flag write issued in the same cycle.
  // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
    end else if (flag_rest) begin
      r_flags <= r_shadow;
    end else if (w_commit) begin
      if (flag_w[1]) begin
        r_flags[FLAG_N] <= alu_flags[FLAG_N];
        r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        r_flags[FLAG_C] <= alu_flags[FLAG_C];
        r_flags[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

  // A simultaneous restore leaves the shadow untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (flag_save && !flag_rest) begin
      r_shadow <= r_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (en && !w_cond_ex && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic
// against a behavioural model of flags, shadow and squash counter.
module tb_cond_unit;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_w;
  logic             pcs, reg_w, mem_w;
  logic             flag_save, flag_rest, cnt_clr;
  logic             pc_src, reg_write, mem_write, cond_ex;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] squash_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_flags;
  logic [3:0] m_shadow;
  int         m_cnt;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .flag_w     (flag_w),
    .pcs        (pcs),
    .reg_w      (reg_w),
    .mem_w      (mem_w),
    .flag_save  (flag_save),
    .flag_rest  (flag_rest),
    .cnt_clr    (cnt_clr),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .cond_ex    (cond_ex),
    .flags_q    (flags_q),
    .squash_cnt (squash_cnt)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Condition table written directly from the architectural rules.
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_flags  = 4'h0;
    m_shadow = 4'h0;
    m_cnt    = 0;
  endtask

  // One instruction: drive at negedge, check gating, clock it, check state.
  task automatic step(input bit i_en, input logic [3:0] i_cond, input logic [3:0] i_alu,
                      input logic [1:0] i_fw, input bit i_pcs, input bit i_reg, input bit i_mem,
                      input bit i_save, input bit i_rest, input bit i_clr);
    bit         ce;
    logic [3:0] nf;
    @(negedge clk);
    en = i_en; cond = i_cond; alu_flags = i_alu; flag_w = i_fw;
    pcs = i_pcs; reg_w = i_reg; mem_w = i_mem;
    flag_save = i_save; flag_rest = i_rest; cnt_clr = i_clr;
    #1;
    ce = model_cond(i_cond, m_flags);
    check("cond_ex",   32'(cond_ex),   32'(ce));
    check("pc_src",    32'(pc_src),    32'(i_en && ce && i_pcs));
    check("reg_write", 32'(reg_write), 32'(i_en && ce && i_reg));
    check("mem_write", 32'(mem_write), 32'(i_en && ce && i_mem));
    @(posedge clk);
    nf = m_flags;
    if (i_rest) nf = m_shadow;
    else if (i_en && ce) begin
      if (i_fw[1]) nf[3:2] = i_alu[3:2];
      if (i_fw[0]) nf[1:0] = i_alu[1:0];
    end
    if (i_save && !i_rest) m_shadow = m_flags;
    if (i_clr) m_cnt = 0;
    else if (i_en && !ce && m_cnt < CNT_MAX) m_cnt++;
    m_flags = nf;
    #1;
    check("flags_q",    32'(flags_q),    32'(m_flags));
    check("squash_cnt", 32'(squash_cnt), 32'(m_cnt));
  endtask

  initial begin
    rst = 1'b1;
    en = 0; cond = 0; alu_flags = 0; flag_w = 0;
    pcs = 0; reg_w = 0; mem_w = 0; flag_save = 0; flag_rest = 0; cnt_clr = 0;
    model_reset();
    #12;
    check("reset_flags", 32'(flags_q), 32'h0);
    check("reset_cnt",   32'(squash_cnt), 32'h0);
    check("reset_pc_src", 32'(pc_src), 32'h0);
    rst = 1'b0;

    // EQ with Z=0 squashes the register write
    step(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    check("t1_cnt", 32'(squash_cnt), 32'd1);

    // AL loads all flags, then EQ passes and memory write commits
    step(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0);
    check("t2_flags", 32'(flags_q), 32'h4);
    step(1, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0);

    // partial flag write keeps C,V
    step(1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0);
    step(1, 4'hE, 4'b0111, 2'b10, 0, 0, 0, 0, 0, 0);
    check("t3_flags", 32'(flags_q), 32'h4);

    // GE passes with N==V; stall blocks both commit and flag write
    step(1, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0);
    step(1, 4'hA, 4'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    step(0, 4'hA, 4'h0, 2'b11, 1, 0, 0, 0, 0, 0);
    check("t4_stall_flags", 32'(flags_q), 32'h9);

    // save, overwrite, restore overriding a same-cycle write
    step(1, 4'hE, 4'b0010, 2'b11, 0, 0, 0, 0, 0, 0);
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, 4'hE, 4'b1100, 2'b11, 0, 0, 0, 0, 0, 0);
    check("t5_mid_flags", 32'(flags_q), 32'hC);
    step(1, 4'hE, 4'b0101, 2'b11, 0, 0, 0, 0, 1, 0);
    check("t5_restored", 32'(flags_q), 32'h2);

    // save and restore together: restore wins, shadow kept
    step(1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0);
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 1, 1, 0);
    check("t5b_both", 32'(flags_q), 32'h2);

    // counter saturation, then clear beats a squash
    step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    check("t6_sat", 32'(squash_cnt), 32'd3);
    step(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 0, 1);
    check("t6_clr", 32'(squash_cnt), 32'd0);

    // randomized traffic with occasional asynchronous reset between edges
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_flags", 32'(flags_q), 32'h0);
        check("async_rst_cnt",   32'(squash_cnt), 32'h0);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
